xif_offload_tracker: RTL
========================

# xif_offload_tracker

Parametrised in-order result tracker for the Core-V eXtension Interface, between the CVA6 offload port and a coprocessor such as Ara.
- Snoops accepted issue transactions and records per-ID commit/kill state.
- Absorbs coprocessor results, which may arrive out of order, into per-ID slots.
- Returns results to the core strictly in issue order, only once committed.
- Silently retires killed instructions; flags protocol violations in a sticky error.

## Interface
- NrIds, default 8: tracked IDs / max outstanding offloads; power of two, ≥2.
- IdWidth, default $clog2(NrIds): width of XIF id fields.
- DataWidth, default 64: result data width (XLEN).
- CntWidth, default $clog2(NrIds+1): outstanding-count width.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- issue_fire_i  in  1  issue valid & ready & accept seen this cycle.
- issue_id_i  in  IdWidth  ID of the accepted instruction.
- full_o  out  1  no free slot; core must not issue.
- commit_valid_i  in  1  commit transaction.
- commit_id_i  in  IdWidth  ID being committed/killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- cop_result_valid_i  in  1  coprocessor result valid.
- cop_result_ready_o  out  1  result accepted; constant 1 outside reset.
- cop_result_id_i  in  IdWidth  result ID.
- cop_result_data_i  in  DataWidth  result data.
- cop_result_rd_i  in  5  destination register.
- cop_result_we_i  in  1  write-back enable.
- cop_result_exc_i  in  1  exception flag.
- cop_result_exccode_i  in  6  exception code.
- core_result_valid_o  out  1  in-order result valid towards core.
- core_result_ready_i  in  1  core accepts result.
- core_result_id_o / data_o / rd_o / we_o / exc_o / exccode_o  out  IdWidth / DataWidth / 5 / 1 / 1 / 6  head result fields.
- outstanding_o  out  CntWidth  occupied slots.
- err_o  out  1  sticky protocol error.

## Operation
- Per-ID state: FREE, ISSUED, COMMITTED, KILLED, plus a res_present bit and a result payload register.
- An order FIFO of depth NrIds holds IDs in issue order. Head pointer, tail pointer and count are all registered.
- Issue:
  - issue_fire_i with slot FREE and !full_o: slot goes to ISSUED, res_present is cleared, ID is pushed at the tail.
  - Issue to a non-FREE ID or while full: ignored, err_o set.
- Commit, for an ISSUED slot: kill=0 moves it to COMMITTED; kill=1 moves it to KILLED.
  - Commit to a FREE, COMMITTED or KILLED slot: ignored, err_o set.
- Result:
  - For ISSUED/COMMITTED without res_present: payload stored, res_present set.
  - For KILLED: payload dropped, res_present set.
  - For FREE, or when res_present is already set: dropped, err_o set.
- Head retire:
  - Head COMMITTED with res_present drives core_result_valid_o=1 with the stored payload. On valid&ready: slot goes to FREE, head is popped.
  - Head KILLED retires without a core transaction, one per cycle, regardless of res_present. A later result for a re-issued ID is then legal.
- full_o = (count == NrIds); outstanding_o = count.
- Count updates with +issue −pop in the same cycle, so issue and pop together leave it unchanged.
- Pointers are IdWidth bits and wrap modulo NrIds.
- err_o is cleared only by reset.

## Timing
- Reset (async assert, sync deassert use): all slots FREE, FIFO empty, core_result_valid_o=0, all payload outputs 0, full_o=0, outstanding_o=0, err_o=0, cop_result_ready_o=0 while rst_ni=0.
- All state updates on clk_i rising edge; events in cycle N are visible in cycle N+1.
- Result arriving for an already-committed head: core_result_valid_o=1 in the next cycle (latency 1).
- Commit and result for the same ID in the same cycle: both apply; valid in the next cycle if it is the head.
- Killed-slot drain: 1 cycle per killed head.
- Kill of a head that already holds a result: data discarded, no core transaction.
- Back-pressure: core_result_valid_o and payload are held stable until core_result_ready_i; the head never changes while valid && !ready.
- Issue while a head pops in the same cycle at full: full_o is registered, so the issue is rejected and err_o is set.
- Issue of an ID freed by a pop in the same cycle: rejected (state is still non-FREE), err_o set.

## Test plan
- In-order basic: issue IDs 0,1,2; commit all; results in order 0,1,2 with data 0xA0,0xA1,0xA2 -> core receives 0xA0,0xA1,0xA2, each one cycle after its result; outstanding_o returns to 0.
- Out-of-order results: issue 3,5,6; commit all; results arrive 6,5,3 -> core sees 3,5,6 in order; the first core valid comes one cycle after ID 3's result.
- Kill: issue 1,2,3; kill 2; results for 1,2,3 -> core sees only 1 and 3; no err_o; outstanding_o=0 at the end.
- Back-pressure: head valid with core_result_ready_i=0 for 5 cycles -> payload stable, no pop; ready=1 -> pop in that cycle.
- Full: issue all 8 IDs -> full_o=1, outstanding_o=8; a ninth issue sets err_o; one retire -> full_o=0 the next cycle.
- Protocol errors: commit of a FREE ID, duplicate result, issue of an in-flight ID -> err_o=1, held until reset; internal state otherwise unchanged.

Source files
------------

// File: rtl/xif_offload_tracker.sv
// xif_offload_tracker: in-order result tracker for XIF offloads.
// Records commit/kill per ID and returns results in issue order.
module xif_offload_tracker #(
  parameter int unsigned NrIds     = 8,
  parameter int unsigned IdWidth   = $clog2(NrIds),
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = $clog2(NrIds + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_fire_i,
  input  logic [IdWidth-1:0]   issue_id_i,
  output logic                 full_o,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  input  logic                 cop_result_valid_i,
  output logic                 cop_result_ready_o,
  input  logic [IdWidth-1:0]   cop_result_id_i,
  input  logic [DataWidth-1:0] cop_result_data_i,
  input  logic [4:0]           cop_result_rd_i,
  input  logic                 cop_result_we_i,
  input  logic                 cop_result_exc_i,
  input  logic [5:0]           cop_result_exccode_i,
  output logic                 core_result_valid_o,
  input  logic                 core_result_ready_i,
  output logic [IdWidth-1:0]   core_result_id_o,
  output logic [DataWidth-1:0] core_result_data_o,
  output logic [4:0]           core_result_rd_o,
  output logic                 core_result_we_o,
  output logic                 core_result_exc_o,
  output logic [5:0]           core_result_exccode_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_ISSUED,
    S_COMMITTED,
    S_KILLED
  } slot_e;

  slot_e                st_q    [NrIds];
  logic [NrIds-1:0]     res_q;
  logic [DataWidth-1:0] data_q  [NrIds];
  logic [4:0]           rd_q    [NrIds];
  logic [NrIds-1:0]     we_q;
  logic [NrIds-1:0]     exc_q;
  logic [5:0]           ecode_q [NrIds];
  logic [IdWidth-1:0]   fifo_q  [NrIds];
  logic [IdWidth-1:0]   head_q;
  logic [IdWidth-1:0]   tail_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 err_q;

  logic [IdWidth-1:0] head_id;
  logic nonempty;
  logic head_ok;
  logic head_kill;
  logic pop;
  logic issue_ok;
  logic commit_ok;
  logic res_ok;
  logic res_store;
  logic err_set;

  assign full_o = (cnt_q == CntWidth'(NrIds));

  // Transaction legality and head retire decisions from current state
  always_comb begin
    head_id   = fifo_q[head_q];
    nonempty  = (cnt_q != '0);
    head_ok   = nonempty && (st_q[head_id] == S_COMMITTED)
                && res_q[head_id];
    head_kill = nonempty && (st_q[head_id] == S_KILLED);
    pop       = (head_ok && core_result_ready_i) || head_kill;
    issue_ok  = issue_fire_i && (st_q[issue_id_i] == S_FREE)
                && !full_o;
    commit_ok = commit_valid_i && (st_q[commit_id_i] == S_ISSUED);
    res_ok    = cop_result_valid_i
                && (st_q[cop_result_id_i] != S_FREE)
                && !res_q[cop_result_id_i];
    res_store = res_ok && (st_q[cop_result_id_i] != S_KILLED);
    err_set   = (issue_fire_i && !issue_ok)
                || (commit_valid_i && !commit_ok)
                || (cop_result_valid_i && !res_ok);
  end

  // Per-ID lifecycle state and result-present flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrIds; i++) st_q[i] <= S_FREE;
      res_q <= '0;
    end else begin
      for (int i = 0; i < NrIds; i++) begin
        if (pop && head_id == IdWidth'(i)) begin
          st_q[i] <= S_FREE;
        end else if (issue_ok && issue_id_i == IdWidth'(i)) begin
          st_q[i] <= S_ISSUED;
        end else if (commit_ok && commit_id_i == IdWidth'(i)) begin
          st_q[i] <= commit_kill_i ? S_KILLED : S_COMMITTED;
        end
        if (issue_ok && issue_id_i == IdWidth'(i)) begin
          res_q[i] <= 1'b0;
        end else if (res_ok && cop_result_id_i == IdWidth'(i)) begin
          res_q[i] <= 1'b1;
        end
      end
    end
  end

  // Result payload capture; killed slots drop their data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrIds; i++) begin
        data_q[i]  <= '0;
        rd_q[i]    <= '0;
        ecode_q[i] <= '0;
      end
      we_q  <= '0;
      exc_q <= '0;
    end else if (res_store) begin
      data_q[cop_result_id_i]  <= cop_result_data_i;
      rd_q[cop_result_id_i]    <= cop_result_rd_i;
      we_q[cop_result_id_i]    <= cop_result_we_i;
      exc_q[cop_result_id_i]   <= cop_result_exc_i;
      ecode_q[cop_result_id_i] <= cop_result_exccode_i;
    end
  end

  // Issue-order FIFO, occupancy count and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrIds; i++) fifo_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (issue_ok) begin
        fifo_q[tail_q] <= issue_id_i;
        tail_q         <= tail_q + IdWidth'(1);
      end
      if (pop) head_q <= head_q + IdWidth'(1);
      cnt_q <= cnt_q + CntWidth'(issue_ok) - CntWidth'(pop);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign cop_result_ready_o    = rst_ni;
  assign core_result_valid_o   = head_ok;
  assign core_result_id_o      = head_ok ? head_id : '0;
  assign core_result_data_o    = head_ok ? data_q[head_id] : '0;
  assign core_result_rd_o      = head_ok ? rd_q[head_id] : '0;
  assign core_result_we_o      = head_ok && we_q[head_id];
  assign core_result_exc_o     = head_ok && exc_q[head_id];
  assign core_result_exccode_o = head_ok ? ecode_q[head_id] : '0;
  assign outstanding_o         = cnt_q;
  assign err_o                 = err_q;

endmodule
